// File: rtl/nonce_sequencer_if.sv
// Host/control and nonce-stream signals of the nonce sequencer.
// Port summary: seed/seed_load/start/stop/batch_len in, nonce/valid out, ready in, busy/done/wrapped status out.
// Optional: NONCE_SEQ_COUNT_EN adds the 64-bit issued_count_o status output.
interface nonce_sequencer_if #(
    parameter int BATCH_WIDTH = 32
);
    logic [255:0]           seed_i;
    logic                   seed_load_i;
    logic                   start_i;
    logic                   stop_i;
    logic [BATCH_WIDTH-1:0] batch_len_i;
    logic [255:0]           nonce_o;
    logic                   nonce_valid_o;
    logic                   nonce_ready_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   wrapped_o;
`ifdef NONCE_SEQ_COUNT_EN
    logic [63:0]            issued_count_o;
`endif

    // master: the sequencer itself; slave: host plus downstream hash core
    modport master (
        input  seed_i, seed_load_i, start_i, stop_i, batch_len_i, nonce_ready_i,
        output nonce_o, nonce_valid_o, busy_o, done_o, wrapped_o
`ifdef NONCE_SEQ_COUNT_EN
        , output issued_count_o
`endif
    );

    modport slave (
        output seed_i, seed_load_i, start_i, stop_i, batch_len_i, nonce_ready_i,
        input  nonce_o, nonce_valid_o, busy_o, done_o, wrapped_o
`ifdef NONCE_SEQ_COUNT_EN
        , input issued_count_o
`endif
    );
endinterface

// File: rtl/nonce_sequencer.sv
// Holds the live 256-bit search nonce and issues one nonce per cycle over valid/ready, adding STRIDE per transfer.
// Latency: first valid one cycle after start_i; one nonce per cycle with ready high.
// Backpressure: nonce_o holds stable while valid & !ready; only handshakes advance the nonce.
// Ports: clk_i, rst_i (synchronous, active-high) plus nonce_sequencer_if.master (control, stream, status).
// Optional feature macro: NONCE_SEQ_COUNT_EN adds a saturating 64-bit handshake counter (issued_count_o).
module nonce_sequencer #(
    parameter logic [7:0] STRIDE      = 8'd1,
    parameter int         BATCH_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    nonce_sequencer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [255:0]           nonce;
    logic [BATCH_WIDTH-1:0] remaining;
    logic                   wrapped;
    logic                   hs;
    logic [255:0]           nonce_inc;
    logic [32:0]            carry;

    assign hs = (state == RUN) && bus.nonce_ready_i;

    // Byte-wise ripple-carry adder: STRIDE enters byte 0, carries ripple up to byte 31.
    // carry[32] is the wrap past 2^256-1.
    assign carry[0] = 1'b0;
    genvar b;
    generate
        for (b = 0; b < 32; b++) begin : g_byte
            localparam logic [7:0] ADDEND = (b == 0) ? STRIDE : 8'd0;
            assign {carry[b+1], nonce_inc[8*b +: 8]} =
                {1'b0, nonce[8*b +: 8]} + {1'b0, ADDEND} + {8'd0, carry[b]};
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start_i) state_nxt = RUN;
            // stop wins over batch completion so an aborted run never pulses done
            RUN: begin
                if (bus.stop_i)
                    state_nxt = IDLE;
                else if (hs && remaining == BATCH_WIDTH'(1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            nonce     <= '0;
            remaining <= '0;
            wrapped   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (bus.seed_load_i) begin
                    nonce   <= bus.seed_i;
                    wrapped <= 1'b0;
                end
                if (bus.start_i)
                    remaining <= bus.batch_len_i;
            end else if (hs) begin
                nonce <= nonce_inc;
                if (carry[32])
                    wrapped <= 1'b1;
                // remaining == 0 means unbounded: never decrement
                if (remaining != '0)
                    remaining <= remaining - BATCH_WIDTH'(1);
            end
        end
    end

`ifdef NONCE_SEQ_COUNT_EN
    logic [63:0] issued_count;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            issued_count <= '0;
        else if (state == IDLE && bus.seed_load_i)
            issued_count <= '0;
        else if (hs && issued_count != '1)
            issued_count <= issued_count + 64'd1;
    end

    assign bus.issued_count_o = issued_count;
`endif

    assign bus.nonce_o       = nonce;
    assign bus.nonce_valid_o = (state == RUN);
    assign bus.busy_o        = (state == RUN);
    assign bus.done_o        = (state == DONE);
    assign bus.wrapped_o     = wrapped;
endmodule

// File: tb/tb_nonce_sequencer.sv
// Self-checking bench for nonce_sequencer: table-driven batch runs plus hand-written corner sequences.
// Two instances: STRIDE 1 (main) and STRIDE 2 (carry into byte 1).
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
module tb_nonce_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nonce_sequencer_if #(.BATCH_WIDTH(32)) bus ();
    nonce_sequencer_if #(.BATCH_WIDTH(32)) bus2 ();

    nonce_sequencer #(.STRIDE(8'd1), .BATCH_WIDTH(32)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    nonce_sequencer #(.STRIDE(8'd2), .BATCH_WIDTH(32)) u_dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    typedef struct {
        logic [255:0] seed;
        int           len;
        logic [255:0] final_nonce;
        int           wrap_k;      // first cycle index with wrapped high, 0 = never
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [255:0] seed, input logic load, input int len);
        @(posedge clk); #1;
        bus.seed_i      = seed;
        bus.seed_load_i = load;
        bus.start_i     = 1'b1;
        bus.batch_len_i = len[31:0];
        @(posedge clk); #1;
        bus.seed_load_i = 1'b0;
        bus.start_i     = 1'b0;
    endtask

    // Checks the tail of a bounded run: DONE pulse, then IDLE holding the final nonce.
    task automatic check_done(input string tag, input logic [255:0] final_nonce);
        @(negedge clk);
        chk({tag, " done"},  256'(bus.done_o), 256'd1);
        chk({tag, " valid in DONE"}, 256'(bus.nonce_valid_o), 256'd0);
        chk({tag, " busy in DONE"},  256'(bus.busy_o), 256'd0);
        @(negedge clk);
        chk({tag, " done clears"}, 256'(bus.done_o), 256'd0);
        chk({tag, " final nonce"}, bus.nonce_o, final_nonce);
    endtask

    initial begin
        bus.seed_i = '0;  bus.seed_load_i = 0; bus.start_i = 0; bus.stop_i = 0;
        bus.batch_len_i = '0; bus.nonce_ready_i = 1'b1;
        bus2.seed_i = '0; bus2.seed_load_i = 0; bus2.start_i = 0; bus2.stop_i = 0;
        bus2.batch_len_i = '0; bus2.nonce_ready_i = 1'b1;

        vecs[0] = '{seed: 256'd0,          len: 4, final_nonce: 256'd4,          wrap_k: 0};
        vecs[1] = '{seed: 256'hFFFFFFFF,   len: 1, final_nonce: 256'h1_00000000, wrap_k: 0};
        vecs[2] = '{seed: {256{1'b1}},     len: 2, final_nonce: 256'd1,          wrap_k: 1};
        vecs[3] = '{seed: {128'd0, {128{1'b1}}}, len: 1,
                    final_nonce: 256'h1_00000000_00000000_00000000_00000000, wrap_k: 0};

        // reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset nonce",   bus.nonce_o, 256'd0);
        chk("reset valid",   256'(bus.nonce_valid_o), 256'd0);
        chk("reset busy",    256'(bus.busy_o), 256'd0);
        chk("reset done",    256'(bus.done_o), 256'd0);
        chk("reset wrapped", 256'(bus.wrapped_o), 256'd0);

        // table-driven bounded batches, ready held high
        for (int i = 0; i < 4; i++) begin
            start_run(vecs[i].seed, 1'b1, vecs[i].len);
            for (int k = 0; k < vecs[i].len; k++) begin
                @(negedge clk);
                chk($sformatf("vec%0d valid k%0d", i, k), 256'(bus.nonce_valid_o), 256'd1);
                chk($sformatf("vec%0d busy k%0d", i, k),  256'(bus.busy_o), 256'd1);
                chk($sformatf("vec%0d nonce k%0d", i, k), bus.nonce_o, vecs[i].seed + 256'(k));
                chk($sformatf("vec%0d wrapped k%0d", i, k), 256'(bus.wrapped_o),
                    256'((vecs[i].wrap_k != 0) && (k >= vecs[i].wrap_k)));
            end
            check_done($sformatf("vec%0d", i), vecs[i].final_nonce);
            chk($sformatf("vec%0d wrapped after", i), 256'(bus.wrapped_o), 256'(vecs[i].wrap_k != 0));
        end

        // backpressure: ready low for 3 cycles after the first transfer
        start_run(256'h100, 1'b1, 3);
        @(negedge clk);
        chk("bp nonce0", bus.nonce_o, 256'h100);
        @(posedge clk); #1 bus.nonce_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold valid %0d", k), 256'(bus.nonce_valid_o), 256'd1);
            chk($sformatf("bp hold nonce %0d", k), bus.nonce_o, 256'h101);
            @(posedge clk); #1;
        end
        bus.nonce_ready_i = 1'b1;
        @(negedge clk);
        chk("bp resume nonce1", bus.nonce_o, 256'h101);
        @(negedge clk);
        chk("bp resume nonce2", bus.nonce_o, 256'h102);
        check_done("bp", 256'h103);

        // stop during the 6th handshake of an unbounded run; seed_load in RUN is ignored
        start_run(256'h10, 1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("stop nonce k%0d", k), bus.nonce_o, 256'h10 + 256'(k));
            @(posedge clk); #1;
            bus.seed_load_i = (k == 1);
            bus.seed_i      = 256'hDEAD;
            bus.stop_i      = (k == 4);
        end
        bus.stop_i = 1'b0;
        @(negedge clk);
        chk("stop valid low", 256'(bus.nonce_valid_o), 256'd0);
        chk("stop busy low",  256'(bus.busy_o), 256'd0);
        chk("stop no done",   256'(bus.done_o), 256'd0);
        chk("stop advanced",  bus.nonce_o, 256'h16);
        @(negedge clk);
        chk("stop still no done", 256'(bus.done_o), 256'd0);
        start_run(256'hBEEF, 1'b0, 1);
        @(negedge clk);
        chk("resume valid", 256'(bus.nonce_valid_o), 256'd1);
        chk("resume nonce", bus.nonce_o, 256'h16);
        check_done("resume", 256'h17);

`ifdef NONCE_SEQ_COUNT_EN
        // counter: two batches of 4 without reseeding, then clear on seed load
        start_run(256'd0, 1'b1, 4);
        repeat (4) @(negedge clk);
        check_done("cnt run1", 256'd4);
        start_run(256'd0, 1'b0, 4);
        repeat (4) @(negedge clk);
        check_done("cnt run2", 256'd8);
        chk("count eight", 256'(bus.issued_count_o), 256'd8);
        @(posedge clk); #1 bus.seed_load_i = 1'b1;
        @(posedge clk); #1 bus.seed_load_i = 1'b0;
        @(negedge clk);
        chk("count cleared", 256'(bus.issued_count_o), 256'd0);
`endif

        // STRIDE 2 instance: byte 0 = 0xFF carries into byte 1
        @(posedge clk); #1;
        bus2.seed_i = 256'h34FF; bus2.seed_load_i = 1'b1; bus2.start_i = 1'b1; bus2.batch_len_i = 32'd2;
        @(posedge clk); #1;
        bus2.seed_load_i = 1'b0; bus2.start_i = 1'b0;
        @(negedge clk);
        chk("s2 nonce0", bus2.nonce_o, 256'h34FF);
        @(negedge clk);
        chk("s2 nonce1", bus2.nonce_o, 256'h3501);
        @(negedge clk);
        chk("s2 done", 256'(bus2.done_o), 256'd1);
        chk("s2 final", bus2.nonce_o, 256'h3503);

        // reset mid-run aborts immediately with no done pulse
        start_run(256'h5, 1'b1, 0);
        @(negedge clk);
        chk("pre-reset valid", 256'(bus.nonce_valid_o), 256'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mid reset valid", 256'(bus.nonce_valid_o), 256'd0);
        chk("mid reset busy",  256'(bus.busy_o), 256'd0);
        chk("mid reset done",  256'(bus.done_o), 256'd0);
        chk("mid reset nonce", bus.nonce_o, 256'd0);
        @(negedge clk);
        chk("mid reset no done later", 256'(bus.done_o), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/nonce_sequencer.md
Name: nonce_sequencer

Overview:
- Holds the live 256-bit search nonce.
- Issues one nonce per cycle to the downstream Skein hash pipeline over a valid/ready handshake.
- Advances the nonce by STRIDE after every accepted transfer, using byte-wise ripple-carry addition across the 32 bytes.
- Sits between the host/control interface, which seeds and starts it, and the hash core.

Parameters:
- STRIDE, 1, amount added per accepted nonce; 8-bit unsigned, legal range 1..255; used to interleave multiple cores.
- BATCH_WIDTH, 32, width of the batch length counter.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; synchronous, active-high
- seed_i  input  256  initial nonce value
- seed_load_i  input  1  load seed_i into the nonce register (honoured in IDLE only)
- start_i  input  1  begin issuing nonces (honoured in IDLE only)
- stop_i  input  1  abort the run (honoured in RUN only)
- batch_len_i  input  BATCH_WIDTH  nonces to issue; 0 = unbounded
- nonce_o  output  256  current nonce
- nonce_valid_o  output  1  nonce_o valid
- nonce_ready_i  input  1  downstream accepts nonce_o
- busy_o  output  1  state is RUN
- done_o  output  1  one-cycle pulse when a bounded batch completes
- wrapped_o  output  1  sticky: the nonce has wrapped past 2^256-1

Behaviour:
- Reset: all registers take their reset values at the next clock edge after rst_i is sampled high.
  - nonce register = 0, state = IDLE, remaining = 0.
  - nonce_valid_o = 0, busy_o = 0, done_o = 0, wrapped_o = 0.
  - Reset mid-run aborts immediately; no done_o pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - seed_load_i=1: nonce register <= seed_i; wrapped_o <= 0.
  - start_i=1: remaining <= batch_len_i; go to RUN.
  - seed_load_i and start_i together: both take effect; the first issued nonce is seed_i.
  - stop_i is ignored.
- RUN:
  - nonce_valid_o = 1 and busy_o = 1 (registered, so high from the cycle after start_i).
  - Start-to-first-valid latency is 1 cycle.
  - nonce_o = nonce register; it holds stable while valid & !ready.
- Handshake (valid & ready): nonce register <= (nonce + STRIDE) mod 2^256.
  - STRIDE is added into byte 0; the carry ripples through bytes 1..31.
  - A carry out of byte 31 sets wrapped_o. Issuing continues after a wrap; the sequencer never halts on wrap.
  - Sustained throughput with ready held high: one nonce per cycle.
- Bounded batch (remaining != 0): each handshake decrements remaining.
  - A handshake with remaining == 1 moves to DONE; nonce_valid_o is 0 from the next cycle.
- Unbounded batch (batch_len 0): remaining is not decremented; the run ends only on stop_i or reset.
- stop_i in RUN:
  - Go to IDLE next cycle; nonce_valid_o drops next cycle.
  - A handshake in the same cycle as stop_i completes and advances the nonce.
  - Retracting valid without a handshake is permitted; the hash core samples only on handshake.
  - No done_o pulse on stop.
- DONE: lasts one cycle with done_o = 1, nonce_valid_o = 0, busy_o = 0; then IDLE.
- Nonce register retains its value across IDLE, so a later start_i without seed_load_i resumes from the next unissued nonce.
- seed_load_i, start_i and batch_len_i are ignored outside IDLE.

Optional Feature:
- Macro NONCE_SEQ_COUNT_EN.
- Defined: adds output issued_count_o (64 bits).
  - Reset = 0; cleared on seed_load_i.
  - Incremented by 1 on every handshake, saturating at 2^64-1.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Seed 0, STRIDE 1, batch 4, ready high: nonce_o = 0,1,2,3 on four consecutive valid cycles → done_o pulse the next cycle → busy_o low → nonce register = 4.
- Carry ripple: seed low 64 bits = 0x00000000_FFFFFFFF, one handshake → 0x00000001_00000000. Seed byte 0 = 0xFF, STRIDE 2 → byte 0 = 0x01, byte 1 incremented by 1.
- Wrap: seed all-ones, STRIDE 1, batch 2 → nonces 2^256-1 then 0; wrapped_o = 1 from the cycle after the first handshake; done_o pulses.
- Backpressure: batch 3, ready low for 3 cycles mid-run → nonce_o stable, valid high, no advance; on resume the sequence continues without skip or duplicate.
- Stop: batch 0, seed 0x10, ready high, stop_i asserted during the 6th handshake → valid low next cycle, no done_o; then start_i alone with batch 1 → first nonce 0x16.
- With NONCE_SEQ_COUNT_EN: run the first scenario twice without reseeding → issued_count_o = 8. seed_load_i → issued_count_o = 0.
